sha256_round_ctrl: RTL and testbench

- Control FSM that sequences one SHA-256 compression per 512-bit block.
- Pulses message_schedule init, then drives its shift/t for 64 rounds and gates the compression-round datapath on schedule valid.
- Finishes each block with the hash-update (H += a..h) strobe.
- Sits between the block-input handshake and the message_schedule + compression core.

---
 rtl/sha_ctrl_pkg.sv | 38 +++
 rtl/sha256_round_ctrl.sv | 121 ++++++++++++
 tb/tb_sha256_round_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/sha_ctrl_pkg.sv
// Shared types and constants for the SHA-256 block controller and compression core.
package sha_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StInit,
    StRound,
    StFinal,
    StDone
  } ctrl_state_e;

  localparam int unsigned ROUNDS_DEFAULT = 64;

  localparam logic [31:0] H0 = 32'h6a09e667;
  localparam logic [31:0] H1 = 32'hbb67ae85;
  localparam logic [31:0] H2 = 32'h3c6ef372;
  localparam logic [31:0] H3 = 32'ha54ff53a;
  localparam logic [31:0] H4 = 32'h510e527f;
  localparam logic [31:0] H5 = 32'h9b05688c;
  localparam logic [31:0] H6 = 32'h1f83d9ab;
  localparam logic [31:0] H7 = 32'h5be0cd19;

  function automatic logic [31:0] sha256_iv(input logic [2:0] idx);
    logic [31:0] iv;
    unique case (idx)
      3'd0:    iv = H0;
      3'd1:    iv = H1;
      3'd2:    iv = H2;
      3'd3:    iv = H3;
      3'd4:    iv = H4;
      3'd5:    iv = H5;
      3'd6:    iv = H6;
      default: iv = H7;
    endcase
    return iv;
  endfunction

endpackage

// File: rtl/sha256_round_ctrl.sv
// Sequences one SHA-256 compression per block: init, ROUNDS gated rounds, hash update, done.
module sha256_round_ctrl
  import sha_ctrl_pkg::*;
#(
  parameter int unsigned ROUNDS = ROUNDS_DEFAULT,
  parameter int unsigned T_W    = 6
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic           first_block,
  input  logic           abort,
  input  logic           sched_valid,
  output logic           ready,
  output logic           sched_init,
  output logic           sched_shift,
  output logic [T_W-1:0] sched_t,
  output logic           h_init,
  output logic           ctx_load,
  output logic           round_en,
  output logic           h_update,
  output logic           busy,
  output logic           done
);

  localparam logic [T_W-1:0] TLast = T_W'(ROUNDS - 1);

  ctrl_state_e    state_q, state_d;
  logic [T_W-1:0] t_q, t_d;
  logic           first_q, first_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      t_q     <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      first_q <= first_d;
    end
  end

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    first_d = first_q;
    unique case (state_q)
      StIdle: begin
        // abort outranks a simultaneous start
        if (start && !abort) begin
          state_d = StInit;
          first_d = first_block;
        end
      end
      StInit: begin
        t_d     = '0;
        state_d = abort ? StIdle : StRound;
      end
      StRound: begin
        if (abort) begin
          state_d = StIdle;
          t_d     = '0;
        end else if (sched_valid) begin
          if (t_q == TLast) begin
            state_d = StFinal;
            t_d     = '0;
          end else begin
            t_d = t_q + 1'b1;
          end
        end
      end
      StFinal: begin
        state_d = abort ? StIdle : StDone;
        t_d     = '0;
      end
      StDone: begin
        state_d = StIdle;
        t_d     = '0;
      end
      default: begin
        state_d = StIdle;
        t_d     = '0;
      end
    endcase
  end

  // Strobes decode from registered state; abort masks every one of them.
  always_comb begin
    ready       = 1'b0;
    busy        = 1'b1;
    sched_init  = 1'b0;
    ctx_load    = 1'b0;
    h_init      = 1'b0;
    round_en    = 1'b0;
    sched_shift = 1'b0;
    h_update    = 1'b0;
    done        = 1'b0;
    unique case (state_q)
      StIdle: begin
        ready = 1'b1;
        busy  = 1'b0;
      end
      StInit: begin
        sched_init = !abort;
        ctx_load   = !abort;
        h_init     = first_q && !abort;
      end
      StRound: begin
        round_en    = sched_valid && !abort;
        sched_shift = sched_valid && !abort;
      end
      StFinal: h_update = !abort;
      StDone:  done     = !abort;
      default: ;
    endcase
  end

  assign sched_t = t_q;

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Directed self-checking bench for sha256_round_ctrl.
module tb_sha256_round_ctrl;

  logic       clk = 1'b0;
  logic       rst_n, start, first_block, abort, sched_valid;
  logic       ready, sched_init, sched_shift, h_init, ctx_load, round_en, h_update, busy, done;
  logic [5:0] sched_t;

  int tests = 0;
  int fails = 0;
  int cycle = 0;

  sha256_round_ctrl #(.ROUNDS(64), .T_W(6)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .first_block (first_block),
    .abort       (abort),
    .sched_valid (sched_valid),
    .ready       (ready),
    .sched_init  (sched_init),
    .sched_shift (sched_shift),
    .sched_t     (sched_t),
    .h_init      (h_init),
    .ctx_load    (ctx_load),
    .round_en    (round_en),
    .h_update    (h_update),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Full block from IDLE; optional stall of stall_n cycles when t reaches stall_t.
  task automatic do_block(input logic fb, input int stall_t, input int stall_n);
    int t0;
    int t;
    int stalled;
    start = 1'b1; first_block = fb; sched_valid = 1'b1; abort = 1'b0;
    #1;
    chk("accept_ready", int'(ready), 1);
    t0 = cycle;
    cyc();
    start = 1'b0; first_block = 1'b0;
    #1;
    chk("init_sched_init", int'(sched_init), 1);
    chk("init_ctx_load", int'(ctx_load), 1);
    chk("init_h_init", int'(h_init), int'(fb));
    chk("init_round_en", int'(round_en), 0);
    chk("init_busy", int'(busy), 1);
    t = 0;
    stalled = 0;
    while (t < 64) begin
      cyc();
      sched_valid = (t == stall_t && stalled < stall_n) ? 1'b0 : 1'b1;
      #1;
      chk("round_t", int'(sched_t), t);
      if (!sched_valid) begin
        chk("stall_round_en", int'(round_en), 0);
        chk("stall_shift", int'(sched_shift), 0);
        stalled++;
      end else begin
        chk("round_en", int'(round_en), 1);
        chk("round_shift", int'(sched_shift), 1);
        chk("round_h_init", int'(h_init), 0);
        t++;
      end
    end
    cyc();
    sched_valid = 1'b1;
    #1;
    chk("final_h_update", int'(h_update), 1);
    chk("final_round_en", int'(round_en), 0);
    chk("final_t", int'(sched_t), 0);
    cyc();
    #1;
    chk("done_pulse", int'(done), 1);
    chk("done_latency", cycle - t0, 67 + stall_n);
    chk("done_ready", int'(ready), 0);
    chk("done_h_update", int'(h_update), 0);
    cyc();
    #1;
    chk("idle_ready", int'(ready), 1);
    chk("idle_done", int'(done), 0);
    chk("idle_latency", cycle - t0, 68 + stall_n);
  endtask

  // Starts a block and stops at the cycle where ROUND presents t = tt.
  task automatic to_round(input int tt);
    start = 1'b1; first_block = 1'b0; sched_valid = 1'b1; abort = 1'b0;
    cyc();
    start = 1'b0;
    cyc();
    repeat (tt) cyc();
  endtask

  initial begin
    int c1, c2, n;
    rst_n = 1'b0; start = 1'b0; first_block = 1'b0; abort = 1'b0; sched_valid = 1'b0;
    #12;
    chk("rst_ready", int'(ready), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_t", int'(sched_t), 0);
    chk("rst_pulses", int'({sched_init, ctx_load, h_init, round_en, h_update, done}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    do_block(1'b1, -1, 0);
    do_block(1'b0, -1, 0);
    do_block(1'b0, 10, 5);

    // Abort mid-round
    to_round(30);
    abort = 1'b1;
    #1;
    chk("abort_t30", int'(sched_t), 30);
    chk("abort_round_en", int'(round_en), 0);
    cyc();
    abort = 1'b0;
    #1;
    chk("abort_ready", int'(ready), 1);
    chk("abort_t_cleared", int'(sched_t), 0);
    chk("abort_no_done", int'(done), 0);
    chk("abort_no_h_update", int'(h_update), 0);
    cyc();
    chk("abort_still_idle", int'(ready), 1);
    do_block(1'b1, -1, 0);

    // Abort coincident with FINAL
    to_round(63);
    cyc();
    abort = 1'b1;
    #1;
    chk("final_abort_busy", int'(busy), 1);
    chk("final_abort_h_update", int'(h_update), 0);
    cyc();
    abort = 1'b0;
    #1;
    chk("final_abort_ready", int'(ready), 1);
    chk("final_abort_no_done", int'(done), 0);

    // start with abort in IDLE is ignored
    start = 1'b1; abort = 1'b1;
    cyc();
    start = 1'b0; abort = 1'b0;
    #1;
    chk("start_abort_idle", int'(ready), 1);
    chk("start_abort_no_init", int'(sched_init), 0);

    // Asynchronous reset mid-round
    to_round(40);
    #1;
    chk("pre_rst_t40", int'(sched_t), 40);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_ready", int'(ready), 1);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_t", int'(sched_t), 0);
    chk("async_rst_round_en", int'(round_en), 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // Back-to-back with start held high
    c1 = -1; c2 = -1; n = 0;
    start = 1'b1; sched_valid = 1'b1;
    for (int i = 0; i < 150; i++) begin
      cyc();
      if (sched_init) begin
        if (n == 0) c1 = cycle;
        else if (n == 1) c2 = cycle;
        n++;
      end
    end
    start = 1'b0;
    chk("b2b_seen_two", int'(n >= 2), 1);
    chk("b2b_spacing", c2 - c1, 68);
    for (int i = 0; i < 200 && !ready; i++) cyc();
    chk("b2b_drain_ready", int'(ready), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
